// File: rtl/scie_cmd_queue.sv
// Command FIFO and response register in front of the combinational SCIE unit.
// Define SCIE_OPCODE_CHK_EN to flag heads whose opcode is not 7'h7B (err=1, data=0).
module scie_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_cmd_valid,
    output logic            io_cmd_ready,
    input  logic [31:0]     io_cmd_insn,
    input  logic [XLEN-1:0] io_cmd_rs1,
    input  logic [XLEN-1:0] io_cmd_rs2,
    output logic [31:0]     io_scie_insn,
    output logic [XLEN-1:0] io_scie_rs1,
    output logic [XLEN-1:0] io_scie_rs2,
    input  logic [XLEN-1:0] io_scie_rd,
    output logic            io_resp_valid,
    input  logic            io_resp_ready,
    output logic [4:0]      io_resp_rd_addr,
    output logic [XLEN-1:0] io_resp_data,
    output logic            io_resp_err,
    output logic            io_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef struct packed {
        logic [31:0]     insn;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } cmd_t;

    cmd_t            mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            resp_valid_q, resp_valid_d;
    logic [4:0]      resp_rd_addr_q, resp_rd_addr_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;

    logic empty, full, push, pop, head_illegal;
    cmd_t head;

    // Extra MSB on the pointers separates full (MSBs differ) from empty (equal).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef SCIE_OPCODE_CHK_EN
    assign head_illegal = !empty && (head.insn[6:0] != 7'h7B);
`else
    assign head_illegal = 1'b0;
`endif

    always_comb begin
        push           = io_cmd_valid && !full;
        pop            = !empty && (!resp_valid_q || io_resp_ready);
        wr_ptr_d       = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d       = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        resp_valid_d   = resp_valid_q;
        resp_rd_addr_d = resp_rd_addr_q;
        resp_data_d    = resp_data_q;
        resp_err_d     = resp_err_q;
        if (pop) begin
            resp_valid_d   = 1'b1;
            resp_rd_addr_d = head.insn[11:7];
            resp_data_d    = head_illegal ? '0 : io_scie_rd;
            resp_err_d     = head_illegal;
        end else if (io_resp_ready) begin
            resp_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            resp_valid_q   <= 1'b0;
            resp_rd_addr_q <= '0;
            resp_data_q    <= '0;
            resp_err_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            resp_valid_q   <= resp_valid_d;
            resp_rd_addr_q <= resp_rd_addr_d;
            resp_data_q    <= resp_data_d;
            resp_err_q     <= resp_err_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{insn: io_cmd_insn, rs1: io_cmd_rs1, rs2: io_cmd_rs2};
        end
    end

    assign io_cmd_ready    = !full;
    assign io_scie_insn    = empty ? '0 : head.insn;
    assign io_scie_rs1     = empty ? '0 : head.rs1;
    assign io_scie_rs2     = empty ? '0 : head.rs2;
    assign io_resp_valid   = resp_valid_q;
    assign io_resp_rd_addr = resp_rd_addr_q;
    assign io_resp_data    = resp_data_q;
    assign io_resp_err     = resp_err_q;
    assign io_busy         = !empty || resp_valid_q;

endmodule

// File: tb/tb_scie_cmd_queue.sv
// Bench for scie_cmd_queue: hand tables, corner sequences and a queue-based reference model.
module tb_scie_cmd_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
`ifdef SCIE_OPCODE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            clock, reset;
    logic            io_cmd_valid, io_cmd_ready;
    logic [31:0]     io_cmd_insn;
    logic [XLEN-1:0] io_cmd_rs1, io_cmd_rs2;
    logic [31:0]     io_scie_insn;
    logic [XLEN-1:0] io_scie_rs1, io_scie_rs2, io_scie_rd;
    logic            io_resp_valid, io_resp_ready;
    logic [4:0]      io_resp_rd_addr;
    logic [XLEN-1:0] io_resp_data;
    logic            io_resp_err, io_busy;

    int errors = 0;
    int checks = 0;
    int n_resp = 0;

    scie_cmd_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
        .io_cmd_insn(io_cmd_insn), .io_cmd_rs1(io_cmd_rs1), .io_cmd_rs2(io_cmd_rs2),
        .io_scie_insn(io_scie_insn), .io_scie_rs1(io_scie_rs1), .io_scie_rs2(io_scie_rs2),
        .io_scie_rd(io_scie_rd),
        .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
        .io_resp_rd_addr(io_resp_rd_addr), .io_resp_data(io_resp_data),
        .io_resp_err(io_resp_err), .io_busy(io_busy)
    );

    // Stand-in SCIE unit: relu of rs1.
    assign io_scie_rd = ($signed(io_scie_rs1) > 0) ? io_scie_rs1 : '0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pending commands in a queue, one response holder.
    typedef struct packed {
        logic [31:0]     insn;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] data;
        logic            err;
    } item_t;

    function automatic item_t mk(input logic [31:0] insn, input logic [XLEN-1:0] rs1,
                                 input logic [XLEN-1:0] rs2);
        item_t it;
        it.insn = insn;
        it.rs1  = rs1;
        it.rs2  = rs2;
        it.err  = CHK && (insn[6:0] != 7'h7B);
        it.data = (it.err || $signed(rs1) <= 0) ? '0 : rs1;
        return it;
    endfunction

    item_t fifo_m[$];
    item_t resp_m;
    bit    resp_v;
    bit    m_pop, m_push;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_m.delete();
            resp_v = 1'b0;
        end else begin
            m_pop  = (fifo_m.size() != 0) && (!resp_v || io_resp_ready);
            m_push = io_cmd_valid && (fifo_m.size() < DEPTH);
            if (m_pop) begin
                resp_m = fifo_m.pop_front();
                resp_v = 1'b1;
            end else if (io_resp_ready) begin
                resp_v = 1'b0;
            end
            if (m_push) fifo_m.push_back(mk(io_cmd_insn, io_cmd_rs1, io_cmd_rs2));
        end
    end

    always @(posedge clock) if (reset && io_resp_valid && io_resp_ready) n_resp++;

    always @(negedge clock) begin
        if (reset) begin
            chk("m_cmd_ready", 64'(io_cmd_ready), 64'(fifo_m.size() < DEPTH));
            chk("m_resp_valid", 64'(io_resp_valid), 64'(resp_v));
            chk("m_busy", 64'(io_busy), 64'((fifo_m.size() != 0) || resp_v));
            if (resp_v) begin
                chk("m_rd_addr", 64'(io_resp_rd_addr), 64'(resp_m.insn[11:7]));
                chk("m_data", 64'(io_resp_data), 64'(resp_m.data));
                chk("m_err", 64'(io_resp_err), 64'(resp_m.err));
            end
            if (fifo_m.size() != 0) begin
                chk("m_head_insn", 64'(io_scie_insn), 64'(fifo_m[0].insn));
                chk("m_head_rs1", 64'(io_scie_rs1), 64'(fifo_m[0].rs1));
                chk("m_head_rs2", 64'(io_scie_rs2), 64'(fifo_m[0].rs2));
            end else begin
                chk("m_head_zero", 64'({io_scie_insn, io_scie_rs1 | io_scie_rs2}), 64'(0));
            end
        end
    end

    typedef struct {
        logic        v;
        logic [31:0] insn;
        logic [31:0] rs1;
        logic        rr;
        logic        e_rdy;
        logic        e_val;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mkv(input bit v, input logic [31:0] insn, input int rs1, input bit rr,
                                 input bit e_rdy, input bit e_val, input int e_rd,
                                 input int e_data, input bit e_busy);
        vec_t r;
        r.v = v; r.insn = insn; r.rs1 = rs1; r.rr = rr;
        r.e_rdy = e_rdy; r.e_val = e_val; r.e_rd = 5'(e_rd);
        r.e_data = e_data; r.e_busy = e_busy;
        return r;
    endfunction

    vec_t tbl[15];

    task automatic drive(input bit v, input logic [31:0] insn, input logic [31:0] rs1, input bit rr);
        io_cmd_valid  = v;
        io_cmd_insn   = insn;
        io_cmd_rs1    = rs1;
        io_cmd_rs2    = $urandom();
        io_resp_ready = rr;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 50 && io_busy; k++) step();
        chk("drain_idle", 64'(io_busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          rs;
        bit          cfail;

        // Single command pair, then back-pressure with DEPTH+1 commands (6th is refused).
        tbl[0]  = mkv(1, 32'h0000057B, -11, 1,  1, 0, 0, 0, 1);
        tbl[1]  = mkv(1, 32'h0000057B,  39, 1,  1, 1, 10, 0, 1);
        tbl[2]  = mkv(0, 32'h0, 0, 1,           1, 1, 10, 39, 1);
        tbl[3]  = mkv(0, 32'h0, 0, 1,           1, 0, 10, 39, 0);
        tbl[4]  = mkv(1, 32'h000000FB,   7, 0,  1, 0, 10, 39, 1);
        tbl[5]  = mkv(1, 32'h0000017B,  35, 0,  1, 1, 1, 7, 1);
        tbl[6]  = mkv(1, 32'h000001FB, -26, 0,  1, 1, 1, 7, 1);
        tbl[7]  = mkv(1, 32'h0000027B,  48, 0,  1, 1, 1, 7, 1);
        tbl[8]  = mkv(1, 32'h000002FB,   1, 0,  0, 1, 1, 7, 1);
        tbl[9]  = mkv(1, 32'h0000037B,  99, 0,  0, 1, 1, 7, 1);
        tbl[10] = mkv(0, 32'h0, 0, 1,           1, 1, 2, 35, 1);
        tbl[11] = mkv(0, 32'h0, 0, 1,           1, 1, 3, 0, 1);
        tbl[12] = mkv(0, 32'h0, 0, 1,           1, 1, 4, 48, 1);
        tbl[13] = mkv(0, 32'h0, 0, 1,           1, 1, 5, 1, 1);
        tbl[14] = mkv(0, 32'h0, 0, 1,           1, 0, 5, 1, 0);

        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        chk("rst_resp_valid", 64'(io_resp_valid), 64'(0));
        chk("rst_cmd_ready", 64'(io_cmd_ready), 64'(1));
        chk("rst_busy", 64'(io_busy), 64'(0));
        chk("rst_rd_addr", 64'(io_resp_rd_addr), 64'(0));
        chk("rst_data", 64'(io_resp_data), 64'(0));
        chk("rst_err", 64'(io_resp_err), 64'(0));
        chk("rst_scie_insn", 64'(io_scie_insn), 64'(0));
        #2 reset = 1'b1;
        @(negedge clock);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].insn, tbl[i].rs1, tbl[i].rr);
            step();
            chk($sformatf("tbl%0d_cmd_ready", i), 64'(io_cmd_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_resp_valid", i), 64'(io_resp_valid), 64'(tbl[i].e_val));
            chk($sformatf("tbl%0d_rd_addr", i), 64'(io_resp_rd_addr), 64'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_data", i), 64'(io_resp_data), 64'(tbl[i].e_data));
            chk($sformatf("tbl%0d_busy", i), 64'(io_busy), 64'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_err", i), 64'(io_resp_err), 64'(0));
        end

        // Full FIFO released while the core keeps offering: one refused cycle, then push+pop.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'h0000007B | (32'(k + 8) << 7), 32'(k * 9 - 20), 1'b0);
            step();
        end
        chk("simul_full_ready", 64'(io_cmd_ready), 64'(0));
        drive(1'b1, 32'h0000077B, 32'd21, 1'b1);
        step();
        chk("simul_after_pop_ready", 64'(io_cmd_ready), 64'(1));
        drive(1'b1, 32'h000007FB, 32'd22, 1'b1);
        step();
        chk("simul_pushpop_ready", 64'(io_cmd_ready), 64'(1));
        chk("simul_pushpop_busy", 64'(io_busy), 64'(1));
        drain();

        // Opcode check: illegal then legal opcode with the same operands.
        drive(1'b1, 32'h00000533, 32'd40, 1'b1);
        step();
        drive(1'b1, 32'h0000057B, 32'd40, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("opc_bad_valid", 64'(io_resp_valid), 64'(1));
        chk("opc_bad_rd", 64'(io_resp_rd_addr), 64'(10));
        chk("opc_bad_data", 64'(io_resp_data), CHK ? 64'(0) : 64'(40));
        chk("opc_bad_err", 64'(io_resp_err), 64'(CHK));
        step();
        chk("opc_good_data", 64'(io_resp_data), 64'(40));
        chk("opc_good_err", 64'(io_resp_err), 64'(0));
        drain();

        // Streaming: 100 back-to-back commands must produce 100 responses in 102 edges.
        n_resp = 0;
        for (int i = 0; i < 102; i++) begin
            r  = $urandom();
            rs = int'($urandom_range(98)) - 48;
            drive(i < 100, {r[31:12], r[4:0], 7'h7B}, rs, 1'b1);
            step();
        end
        chk("stream_count", 64'(n_resp), 64'(100));
        drain();

        // Random valid/ready/opcode traffic against the model.
        for (int i = 0; i < 300; i++) begin
            r  = $urandom();
            rs = int'($urandom_range(98)) - 48;
            drive($urandom_range(9) < 7, {r[31:12], r[4:0], (r[6:5] == 2'b00) ? 7'h33 : 7'h7B},
                  rs, $urandom_range(9) < 6);
            step();
        end
        drain();

        // Reset mid-run with three commands held (one in the response register).
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h0000037B, 32'(k + 3), 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        cfail = !io_busy;
        chk("prerst_busy", 64'(cfail), 64'(0));
        #2 reset = 1'b0;
        #1;
        chk("midrst_resp_valid", 64'(io_resp_valid), 64'(0));
        chk("midrst_busy", 64'(io_busy), 64'(0));
        chk("midrst_cmd_ready", 64'(io_cmd_ready), 64'(1));
        chk("midrst_data", 64'(io_resp_data), 64'(0));
        chk("midrst_scie_insn", 64'(io_scie_insn), 64'(0));
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        drive(1'b1, 32'h0000047B, 32'd5, 1'b1);
        step();
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("postrst_rd", 64'(io_resp_rd_addr), 64'(8));
        chk("postrst_data", 64'(io_resp_data), 64'(5));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
